// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_4to1 scan sequencer.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {IDLE, DWELL, HOLD} scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest set bit of mask strictly above cur.
// With first=1 the search starts below channel 0, i.e. it returns the lowest set bit.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             first,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Descending scan so the lowest qualifying channel is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Sweeps the enabled channels of a mux_4to1 in ascending order, dwelling on
// each select before sampling y_in, and offers the assembled word on a
// valid/ready handshake.
// Optional: MUX_SCAN_AUTORESTART_EN makes the HOLD handshake restart the
// same scan instead of returning to IDLE.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  ch_en,
    output logic [SEL_W-1:0] s,
    input  logic             y_in,
    output logic [N_CH-1:0]  word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy
);

    // The DWELL parameter hides the package's DWELL state name, so the state
    // is always written fully qualified.
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    scan_state_t      state_q, state_d;
    logic [N_CH-1:0]  en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] s_d;
    logic [N_CH-1:0]  word_d;
    logic             vld_d;

    logic [N_CH-1:0]  first_mask;
    logic [SEL_W-1:0] first_ch, next_ch;
    logic             first_found, next_found;

    // In IDLE the first channel comes from the live mask; on a restart it
    // comes from the latched one.
    assign first_mask = (state_q == IDLE) ? ch_en : en_q;

    mux_scan_next_ch u_first (
        .mask  (first_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_ch),
        .found (first_found)
    );

    mux_scan_next_ch u_next (
        .mask  (en_q),
        .cur   (s),
        .first (1'b0),
        .nxt   (next_ch),
        .found (next_found)
    );

    assign busy = (state_q != IDLE);

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        cnt_d   = cnt_q;
        s_d     = s;
        word_d  = word;
        vld_d   = word_valid;
        case (state_q)
            IDLE: begin
                // first_found doubles as the ch_en != 0 test
                if (start && first_found) begin
                    en_d    = ch_en;
                    word_d  = '0;
                    s_d     = first_ch;
                    cnt_d   = DWELL_M1;
                    state_d = mux_scan_pkg::DWELL;
                end
            end
            mux_scan_pkg::DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    word_d[s] = y_in;
                    if (next_found) begin
                        s_d   = next_ch;
                        cnt_d = DWELL_M1;
                    end else begin
                        state_d = HOLD;
                        vld_d   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (word_valid && word_ready) begin
                    vld_d = 1'b0;
`ifdef MUX_SCAN_AUTORESTART_EN
                    word_d  = '0;
                    s_d     = first_ch;
                    cnt_d   = DWELL_M1;
                    state_d = mux_scan_pkg::DWELL;
`else
                    s_d     = '0;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= '0;
            cnt_q      <= '0;
            s          <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cnt_q      <= cnt_d;
            s          <= s_d;
            word       <= word_d;
            word_valid <= vld_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench: the stimulus pushes the expected word, its due cycle and
// the expected select sequence; a negedge monitor pops and compares.
module tb_mux_scan_sequencer;

    localparam int DW = 2;

    logic       clk = 1'b0;
    logic       rst, start, y_in, word_valid, word_ready, busy;
    logic [3:0] ch_en, word, x_vec;
    logic [1:0] s;

    always #5 clk = ~clk;

    // mux_4to1 model driven by the sequencer's select
    assign y_in = x_vec[s];

    mux_scan_sequencer #(.DWELL(DW), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ch_en      (ch_en),
        .s          (s),
        .y_in       (y_in),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] w;
        int         due;
    } exp_t;

    exp_t wq[$];
    int   sq[$];
    exp_t e;

    logic       expect_idle = 1'b0;
    logic       prev_vld    = 1'b0;
    logic [3:0] held_w      = '0;
    logic [1:0] held_s      = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: select sequence during the scan, word and latency at valid
    // rise, stability while held, and the return to idle after a handshake.
    always @(negedge clk) begin
        if (rst) begin
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("post_hs_busy", busy, 0);
                chk("post_hs_valid", word_valid, 0);
                chk("post_hs_s", s, 0);
                chk("post_hs_word", word, held_w);
                expect_idle = 1'b0;
            end
            if (busy && !word_valid) begin
                if (sq.size() == 0) chk("s_seq_overrun", busy, 0);
                else                chk("s_seq", s, sq.pop_front());
            end
            if (word_valid && !prev_vld) begin
                if (wq.size() == 0) begin
                    chk("unexpected_valid", word_valid, 0);
                end else begin
                    e = wq.pop_front();
                    chk("word", word, e.w);
                    chk("latency", cyc, e.due);
                    chk("s_seq_left", sq.size(), 0);
                end
                held_w = word;
                held_s = s;
            end else if (word_valid) begin
                chk("hold_word", word, held_w);
                chk("hold_s", s, held_s);
            end
            if (word_valid && word_ready) expect_idle = 1'b1;
        end
        prev_vld = word_valid;
    end

    task automatic expect_scan(input logic [3:0] x, input logic [3:0] en);
        wq.push_back('{w: x & en, due: cyc + $countones(en) * DW});
        for (int i = 0; i < 4; i++)
            if (en[i]) repeat (DW) sq.push_back(i);
    endtask

    task automatic do_scan(input logic [3:0] x, input logic [3:0] en, input int delay);
        int t;
        x_vec      = x;
        start      = 1'b1;
        ch_en      = en;
        word_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        ch_en = 4'($urandom);
        if (en == 4'b0000) begin
            repeat (3) begin
                @(negedge clk);
                chk("zero_en_busy", busy, 0);
                chk("zero_en_valid", word_valid, 0);
            end
            return;
        end
        expect_scan(x, en);
        t = 0;
        while (!word_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!word_valid) begin
            chk("valid_timeout", word_valid, 1);
            return;
        end
        // back-pressure; a start here must be ignored
        repeat (delay) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            ch_en = 4'($urandom);
        end
        @(posedge clk); #1;
        word_ready = 1'b1;
        start      = 1'b1;
        ch_en      = 4'hF;
        @(posedge clk); #1;
        word_ready = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        ch_en      = '0;
        word_ready = 1'b0;
        x_vec      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_word", word, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_scan(4'b1010, 4'b1111, 0);
        do_scan(4'b1111, 4'b0101, 5);
        do_scan(4'b1111, 4'b0000, 0);

        // reset lands on the 3rd cycle of a 4-channel scan
        x_vec = 4'b1111;
        start = 1'b1;
        ch_en = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        expect_scan(x_vec, 4'b1111);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        sq.delete();
        @(negedge clk);
        chk("midrst_s", s, 0);
        chk("midrst_word", word, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", word_valid, 0);
        @(posedge clk); #1;

        do_scan(4'b0110, 4'b1111, 1);

        for (int n = 0; n < 30; n++)
            do_scan(4'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 4));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream control stage for mux_4to1: drives its 2-bit select `s` and samples its output `y`.
- Sweeps the enabled channels in ascending order, holding each select for DWELL cycles so the mux output settles.
- Assembles the samples into a 4-bit word and offers it on a valid/ready handshake.
- Converts the stateless 4:1 mux into a serialised 4-channel capture path.

Parameters:
- DWELL, 2, cycles each select is held before `y_in` is sampled; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a scan; honoured only in IDLE
- ch_en  in  4  channel enable mask; latched on accepted start
- s  out  2  select to mux_4to1 `s`
- y_in  in  1  from mux_4to1 `y`
- word  out  4  captured word; bit i = sample of channel i
- word_valid  out  1  word available
- word_ready  in  1  consumer accepts word
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: s=0, word=0, word_valid=0, busy=0, state=IDLE, en_q=0, counter=0.
- FSM states: IDLE, DWELL, HOLD.
- IDLE, start=1 and ch_en!=0:
  - en_q<=ch_en; word<=0.
  - s<=lowest set bit of ch_en; cnt<=DWELL-1; next state DWELL.
- IDLE, start=1 and ch_en==0: ignored; stay in IDLE; no output change.
- DWELL, cnt!=0: cnt<=cnt-1; s is held.
- DWELL, cnt==0:
  - word[s]<=y_in.
  - If en_q has a set bit above s: s<=next higher set bit; cnt<=DWELL-1.
  - Otherwise: next state HOLD; word_valid<=1.
- HOLD:
  - word, word_valid and s stay stable until word_valid&&word_ready.
  - On handshake: word_valid<=0; next state IDLE; s<=0; word retains its value.
- Latency: with k enabled channels, word_valid rises exactly k*DWELL cycles after the edge on which start is accepted.
- Bits of disabled channels read 0.
- `start` in DWELL or HOLD is ignored; no queuing.
- `ch_en` changes after acceptance have no effect, because en_q is used.
- word_ready while word_valid=0 is ignored.
- Handshake and start in the same HOLD cycle: only the handshake takes effect; that start is dropped.
- rst asserted mid-scan or in HOLD: every register returns to its reset value on that edge; any partial word is discarded.
- Select arithmetic: 2-bit, no wrap. The scan never returns from channel 3 to channel 0 within one scan.

Optional Feature:
- Macro: MUX_SCAN_AUTORESTART_EN.
- Defined: on the HOLD handshake the block re-enters DWELL with the same en_q and s=lowest set bit of en_q, instead of going to IDLE.
  - word<=0 on re-entry.
  - busy stays 1.
  - Only rst stops the loop.
  - `start` is don't-care after the first scan.
- Undefined: behaviour exactly as above; HOLD returns to IDLE.

Decomposition:
- mux_scan_pkg holds:
  - N_CH=4 and SEL_W=2.
  - typedef enum logic [1:0] {IDLE, DWELL, HOLD} scan_state_t.
- One sub-module, mux_scan_next_ch: combinational.
  - Inputs: mask[3:0] and cur[1:0].
  - Outputs: nxt[1:0] (lowest set bit strictly above cur) and found.
  - A first-channel lookup reuses it with an "above -1" mode input `first`.

Test Plan:
- DUT drives mux_4to1 with x=4'b1010; DWELL=2; start with ch_en=4'b1111 -> s steps 0,1,2,3 with each value held 2 cycles; word_valid rises 8 cycles after start; word=4'b1010.
- ch_en=4'b0101, x=4'b1111 -> only s=0 and s=2 are driven; word=4'b0101; word_valid 4 cycles after start.
- HOLD with word_ready=0 for 5 cycles, then 1 -> word and s stable throughout; return to IDLE on the following edge; busy drops; a start during HOLD is ignored.
- start with ch_en=4'b0000 -> busy remains 0; word_valid never asserts.
- rst asserted on the 3rd cycle of a 4-channel scan -> next edge gives s=0, word=0, busy=0, word_valid=0; a subsequent start completes normally.
- With MUX_SCAN_AUTORESTART_EN defined, ch_en=4'b0011 and word_ready tied to 1 -> a word_valid pulse every 2*DWELL+1 cycles (the extra cycle is the HOLD handshake); busy constantly 1.
